sram_addr_req_queue: RTL and testbench

- Elastic address request queue between the test Driver's address interface and the Single/Multi SRAM controller's addr_valid/addr_ready/addr interface.
- Buffers up to DEPTH read addresses.
- Tracks reads issued to the controller but not yet returned on the data interface, and stops issuing once MAX_OUTSTANDING is reached.
- Lets the Driver run ahead of the controller without overrunning the response path.

---
 rtl/sram_addr_req_queue.sv | 109 ++++++++++
 tb/tb_sram_addr_req_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_addr_req_queue.sv
// Elastic read-address queue between the Driver and the SRAM controller, throttled by reads in flight.
// Optional stall statistics are enabled by defining SRAM_ADDR_REQ_QUEUE_STATS_EN.
module sram_addr_req_queue #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_addr_valid_i,
  output logic                    s_addr_ready_o,
  input  logic [ADDR_WIDTH-1:0]   s_addr_i,
  output logic                    m_addr_valid_o,
  input  logic                    m_addr_ready_i,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  input  logic                    rsp_valid_i,
  input  logic                    rsp_ready_i,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic [7:0]              outstanding_o,
  output logic                    err_o
`ifdef SRAM_ADDR_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0]             stall_full_cnt_o,
  output logic [31:0]             stall_throttle_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  rsp_hs;
  logic                  throttled;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign throttled = (outstanding_o >= MAX_OUT);

  assign s_addr_ready_o = !full;
  assign m_addr_valid_o = !empty && !throttled;
  assign m_addr_o       = mem[rd_ptr[IDX_W-1:0]];
  assign occupancy_o    = wr_ptr - rd_ptr;

  assign push   = s_addr_valid_i && s_addr_ready_o;
  assign pop    = m_addr_valid_o && m_addr_ready_i;
  assign rsp_hs = rsp_valid_i && rsp_ready_i;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= s_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Issue is blocked at MAX_OUTSTANDING, so the increment cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      unique case ({pop, rsp_hs})
        2'b10: outstanding_o <= outstanding_o + 8'd1;
        2'b01: begin
          if (outstanding_o == '0) begin
            err_o <= 1'b1;
          end else begin
            outstanding_o <= outstanding_o - 8'd1;
          end
        end
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

`ifdef SRAM_ADDR_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_full_cnt_o     <= '0;
      stall_throttle_cnt_o <= '0;
    end else begin
      if (s_addr_valid_i && full && (stall_full_cnt_o != '1)) begin
        stall_full_cnt_o <= stall_full_cnt_o + 32'd1;
      end
      if (!empty && (outstanding_o == MAX_OUT) && (stall_throttle_cnt_o != '1)) begin
        stall_throttle_cnt_o <= stall_throttle_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_addr_req_queue.sv
// Directed self-checking bench for sram_addr_req_queue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_sram_addr_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_addr;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  occ;
  logic [7:0]  outst;
  logic        err;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sram_addr_req_queue #(
    .ADDR_WIDTH(12),
    .DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_addr_valid_i(s_valid),
    .s_addr_ready_o(s_ready),
    .s_addr_i(s_addr),
    .m_addr_valid_o(m_valid),
    .m_addr_ready_i(m_ready),
    .m_addr_o(m_addr),
    .rsp_valid_i(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .occupancy_o(occ),
    .outstanding_o(outst),
    .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid   = 1'b0;
    s_addr    = '0;
    m_ready   = 1'b0;
    rsp_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    vectors++; if (occ !== 3'd0) begin miscompares++; $display("FAIL reset_occ got %0d exp 0", occ); end
    vectors++; if (outst !== 8'd0) begin miscompares++; $display("FAIL reset_outst got %0d exp 0", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_single();
    do_reset();
    s_valid = 1'b1; s_addr = 12'h123; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", m_valid); end
    vectors++; if (m_addr !== 12'h123) begin miscompares++; $display("FAIL single_addr got %h exp 123", m_addr); end
    vectors++; if (outst !== 8'd0) begin miscompares++; $display("FAIL single_outst_pre got %0d exp 0", outst); end
    tick();
    m_ready = 1'b0;
    vectors++; if (outst !== 8'd1) begin miscompares++; $display("FAIL single_outst got %0d exp 1", outst); end
    vectors++; if (occ !== 3'd0) begin miscompares++; $display("FAIL single_occ got %0d exp 0", occ); end
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (outst !== 8'd0) begin miscompares++; $display("FAIL single_rsp_outst got %0d exp 0", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b exp 0", err); end
  endtask

  task automatic test_fill();
    logic [11:0] exp_order [5];
    exp_order = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1; s_addr = 12'(i);
      vectors++;
      if (s_ready !== (i <= 4)) begin
        miscompares++; $display("FAIL fill_ready_%0d got %b exp %b", i, s_ready, (i <= 4));
      end
      if (i <= 4) tick();
    end
    vectors++; if (occ !== 3'd4) begin miscompares++; $display("FAIL fill_occ got %0d exp 4", occ); end
    // Responses run alongside issues so the throttle never engages during the drain.
    m_ready = 1'b1; rsp_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_addr !== exp_order[k]) begin
        miscompares++; $display("FAIL fill_order_%0d got v=%b a=%h exp v=1 a=%h", k, m_valid, m_addr, exp_order[k]);
      end
      if (k == 0) begin
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_pop_ready got %b exp 0", s_ready); end
      end
      tick();
      if (k == 0) begin
        vectors++; if (occ !== 3'd3) begin miscompares++; $display("FAIL fill_occ_after_pop got %0d exp 3", occ); end
      end
      if (k == 1) s_valid = 1'b0;
    end
    idle_inputs();
    vectors++; if (m_valid !== 1'b0 || occ !== 3'd0) begin miscompares++; $display("FAIL fill_drained got v=%b occ=%0d exp v=0 occ=0", m_valid, occ); end
    vectors++; if (outst !== 8'd0 || err !== 1'b0) begin miscompares++; $display("FAIL fill_acct got outst=%0d err=%b exp 0 0", outst, err); end
  endtask

  task automatic test_throttle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_addr = 12'(12'h010 + i);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL thr_valid got %b exp 0", m_valid); end
    vectors++; if (m_addr !== 12'h012) begin miscompares++; $display("FAIL thr_addr got %h exp 012", m_addr); end
    vectors++; if (outst !== 8'd2 || occ !== 3'd1) begin miscompares++; $display("FAIL thr_counts got outst=%0d occ=%0d exp 2 1", outst, occ); end
    tick();
    vectors++; if (m_valid !== 1'b0 || outst !== 8'd2) begin miscompares++; $display("FAIL thr_hold got v=%b outst=%0d exp 0 2", m_valid, outst); end
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_addr !== 12'h012 || outst !== 8'd1) begin
      miscompares++; $display("FAIL thr_release got v=%b a=%h outst=%0d exp 1 012 1", m_valid, m_addr, outst);
    end
    tick();
    vectors++; if (outst !== 8'd2 || occ !== 3'd0 || m_valid !== 1'b0) begin
      miscompares++; $display("FAIL thr_reissue got outst=%0d occ=%0d v=%b exp 2 0 0", outst, occ, m_valid);
    end
    m_ready = 1'b0; rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    tick();
    idle_inputs();
    vectors++; if (outst !== 8'd0 || err !== 1'b0) begin miscompares++; $display("FAIL thr_drain got outst=%0d err=%b exp 0 0", outst, err); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_addr = 12'(12'h020 + i);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    vectors++; if (occ !== 3'd2 || outst !== 8'd1 || m_valid !== 1'b1) begin
      miscompares++; $display("FAIL sim_setup got occ=%0d outst=%0d v=%b exp 2 1 1", occ, outst, m_valid);
    end
    s_valid = 1'b1; s_addr = 12'h023; rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    vectors++; if (occ !== 3'd2) begin miscompares++; $display("FAIL sim_occ got %0d exp 2", occ); end
    vectors++; if (outst !== 8'd1) begin miscompares++; $display("FAIL sim_outst got %0d exp 1", outst); end
    vectors++; if (m_addr !== 12'h022) begin miscompares++; $display("FAIL sim_head got %h exp 022", m_addr); end
    tick();
    vectors++; if (m_addr !== 12'h023 || m_valid !== 1'b1) begin miscompares++; $display("FAIL sim_tail got v=%b a=%h exp 1 023", m_valid, m_addr); end
    tick();
    m_ready = 1'b0;
    tick();
    idle_inputs();
    vectors++; if (outst !== 8'd0 || occ !== 3'd0 || err !== 1'b0) begin
      miscompares++; $display("FAIL sim_drain got outst=%0d occ=%0d err=%b exp 0 0 0", outst, occ, err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL uf_err got %b exp 1", err); end
    vectors++; if (outst !== 8'd0) begin miscompares++; $display("FAIL uf_outst got %0d exp 0", outst); end
    s_valid = 1'b1; s_addr = 12'h030; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    vectors++; if (err !== 1'b1 || outst !== 8'd1) begin miscompares++; $display("FAIL uf_sticky got err=%b outst=%0d exp 1 1", err, outst); end
    rsp_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_ready = 1'b0;
    vectors++; if (err !== 1'b1 || outst !== 8'd0) begin miscompares++; $display("FAIL uf_sticky2 got err=%b outst=%0d exp 1 0", err, outst); end
    do_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL uf_clear got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_addr = 12'(12'h040 + i);
      tick();
    end
    s_addr = 12'h044; m_ready = 1'b1;
    tick();
    tick();
    idle_inputs();
    vectors++; if (occ !== 3'd3 || outst !== 8'd2) begin miscompares++; $display("FAIL rm_setup got occ=%0d outst=%0d exp 3 2", occ, outst); end
    // Handshakes are all active in the reset cycle; reset must win.
    s_valid = 1'b1; s_addr = 12'h055; m_ready = 1'b1; rsp_valid = 1'b1; rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    vectors++; if (occ !== 3'd0 || outst !== 8'd0) begin miscompares++; $display("FAIL rm_counts got occ=%0d outst=%0d exp 0 0", occ, outst); end
    vectors++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL rm_flags got v=%b rdy=%b err=%b exp 0 1 0", m_valid, s_ready, err);
    end
    s_valid = 1'b1; s_addr = 12'h3FF; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_addr !== 12'h3FF) begin miscompares++; $display("FAIL rm_push got v=%b a=%h exp 1 3ff", m_valid, m_addr); end
    tick();
    idle_inputs();
    vectors++; if (outst !== 8'd1 || occ !== 3'd0) begin miscompares++; $display("FAIL rm_issue got outst=%0d occ=%0d exp 1 0", outst, occ); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_fill();
    test_throttle();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
